nv_scene_sequencer: RTL
=======================

// Module: nv_scene_sequencer
// PURPOSE
//  Frame-synchronous controller that decides the 8-bit segment mask shown by the VGA renderer.
//  Runs a countdown attract loop, debounces user input, and switches to LIVE display; returns to attract after idle.
//  Also supplies the animation phase for the horizon grid.
//  Sits between ui_in / hvsync_generator and the pixel datapath in tt_um_nvious_graphics; clocked on the pixel clk, not on vsync.
// PARAMETERS
//  FRAMES_PER_DIGIT  64    frames each countdown ROM entry is held; power of 2, >=2
//  IDLE_FRAMES       1800  consecutive all-zero input frames in LIVE before returning to COUNTDOWN; >=2
//  IDLE_W            11    width of idle counter; 2**IDLE_W > IDLE_FRAMES
// PORTS
//  clk         in   1  pixel clock
//  rst_n       in   1  reset, asynchronous, active-low
//  vsync       in   1  vsync from hvsync_generator, already in clk domain
//  ui_in       in   8  requested segment mask (bit0=a .. bit6=g, bit7=dp)
//  seg_mask    out  8  registered mask for the renderer
//  anim_phase  out  7  frame counter for horizon animation
//  scene_state out  2  00=COUNTDOWN 01=ARMED 10=LIVE (11 unused)
//  frame_tick  out  1  one-cycle pulse, cycle after vsync rising edge
// BEHAVIOUR
//  Reset (async assert, sync use after deassert):
//  - state=COUNTDOWN, digit_idx=0, fcnt=0, idle=0, anim_phase=0, seg_mask=8'h67 (ROM[0]), frame_tick=0
//  - vs_q=1, so vsync high at reset release gives no tick
//  Tick: frame_tick = vsync & ~vs_q, registered. All state/output updates occur only in the tick cycle.
//  Between ticks every output holds (no mid-frame tearing).
//  anim_phase: +1 every tick in all states; wraps 127->0.
//  Countdown ROM (16 x 8): 67,7F,07,7D,6D,66,4F,5B,06,3F,80,00,80,00,80,00 (hex).
//  Digit timer runs in COUNTDOWN and ARMED on each tick:
//  - fcnt==FRAMES_PER_DIGIT-1: fcnt<=0, digit_idx<=digit_idx+1 (mod 16, 15->0)
//  - else fcnt<=fcnt+1
//  COUNTDOWN, on tick:
//  - ui_in!=0: cap<=ui_in, ->ARMED, seg_mask keeps countdown value
//  - else: seg_mask<=ROM[next digit_idx]
//  ARMED, on tick:
//  - ui_in==cap: ->LIVE, seg_mask<=cap, idle<=0
//  - ui_in!=0 and ui_in!=cap: cap<=ui_in, stay ARMED
//  - ui_in==0: ->COUNTDOWN
//  - Countdown seg_mask continues updating while ARMED.
//  LIVE, on tick:
//  - seg_mask<=ui_in (zero allowed: blank)
//  - ui_in!=0: idle<=0
//  - else idle<=idle+1, saturating
//  - When idle reaches IDLE_FRAMES: ->COUNTDOWN, digit_idx=0, fcnt=0, seg_mask=ROM[0], idle=0
//  - digit_idx/fcnt are frozen in LIVE.
//  Debounce: a value must be sampled identical and nonzero on two consecutive ticks. Glitches shorter than one frame are ignored.
//  ui_in is sampled only in the tick cycle; changes on other cycles have no effect.
//  Reset mid-frame or mid-ARMED: immediate return to reset values; cap discarded.
// STRUCTURE
//  Package nv_gfx_pkg: scene_state_t enum (COUNTDOWN/ARMED/LIVE), COUNTDOWN_ROM constant, SEG_W=8, ANIM_W=7.
//  Sub-module nv_frame_tick: vsync edge detector producing frame_tick (vs_q reset to 1).
//  Remainder in one always_ff: FSM, digit timer, idle counter, output regs.
// TESTING (sim: FRAMES_PER_DIGIT=4, IDLE_FRAMES=8)
//  1 Reset, ui_in=0, 5 vsync pulses -> seg_mask 67,67,67,7F,7F; anim_phase=5; state 00.
//  2 ui_in=0 for 64 ticks -> digit_idx wraps 15->0; seg_mask returns to 67 at tick 64; anim_phase wraps at tick 128.
//  3 ui_in=8'h5B for 1 tick then 0 -> ARMED then COUNTDOWN; seg_mask never 5B.
//    ui_in=5B for 2 ticks -> LIVE, seg_mask=5B exactly on 2nd tick.
//  4 ARMED with cap=5B, next tick ui_in=06 -> stay ARMED with cap=06; following tick 06 -> LIVE, seg_mask=06.
//  5 LIVE, ui_in=0 for 7 ticks -> LIVE, seg_mask=00.
//    8th tick -> COUNTDOWN, seg_mask=67.
//    Nonzero input at tick 5 -> idle restarts.
//  6 Hold vsync high across rst_n release -> no frame_tick.
//    rst_n low mid-LIVE -> seg_mask=67, state=00 immediately.
//    ui_in toggled between ticks -> no output change.

Source files
------------

// File: rtl/nv_gfx_pkg.sv
// rtl/nv_gfx_pkg.sv - shared types and constants for the scene sequencer
package nv_gfx_pkg;

    localparam int SEG_W  = 8;
    localparam int ANIM_W = 7;

    typedef enum logic [1:0] {
        COUNTDOWN = 2'b00,
        ARMED     = 2'b01,
        LIVE      = 2'b10
    } scene_state_t;

    // Entry 0 is the rightmost byte: 67,7F,07,7D,6D,66,4F,5B,06,3F,80,00,80,00,80,00
    localparam logic [15:0][SEG_W-1:0] COUNTDOWN_ROM = {
        8'h00, 8'h80, 8'h00, 8'h80, 8'h00, 8'h80, 8'h3F, 8'h06,
        8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h67
    };

endpackage

// File: rtl/nv_frame_tick.sv
// rtl/nv_frame_tick.sv - vsync rising-edge detector giving a one-cycle frame tick
module nv_frame_tick (
    input  logic clk,
    input  logic rst_n,
    input  logic vsync,
    output logic frame_tick
);

    logic vs_q;

    // vs_q resets high so a vsync already high at reset release does not tick
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_q       <= 1'b1;
            frame_tick <= 1'b0;
        end else begin
            vs_q       <= vsync;
            frame_tick <= vsync & ~vs_q;
        end
    end

endmodule

// File: rtl/nv_scene_sequencer.sv
// rtl/nv_scene_sequencer.sv - frame-synchronous attract/armed/live segment mask sequencer
module nv_scene_sequencer
    import nv_gfx_pkg::*;
#(
    parameter int FRAMES_PER_DIGIT = 64,
    parameter int IDLE_FRAMES      = 1800,
    parameter int IDLE_W           = 11
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              vsync,
    input  logic [SEG_W-1:0]  ui_in,
    output logic [SEG_W-1:0]  seg_mask,
    output logic [ANIM_W-1:0] anim_phase,
    output logic [1:0]        scene_state,
    output logic              frame_tick
);

    localparam int FC_W = $clog2(FRAMES_PER_DIGIT);

    scene_state_t      state;
    logic [FC_W-1:0]   fcnt;
    logic [3:0]        digit_idx;
    logic [IDLE_W-1:0] idle;
    logic [SEG_W-1:0]  cap;

    logic              fcnt_wrap;
    logic [FC_W-1:0]   fcnt_next;
    logic [3:0]        digit_next;
    logic [IDLE_W-1:0] idle_inc;

    nv_frame_tick u_frame_tick (
        .clk        (clk),
        .rst_n      (rst_n),
        .vsync      (vsync),
        .frame_tick (frame_tick)
    );

    always_comb begin
        fcnt_wrap  = (fcnt == FC_W'(FRAMES_PER_DIGIT - 1));
        fcnt_next  = fcnt_wrap ? '0 : fcnt + FC_W'(1);
        digit_next = fcnt_wrap ? digit_idx + 4'd1 : digit_idx;
        idle_inc   = (idle == {IDLE_W{1'b1}}) ? idle : idle + IDLE_W'(1);
    end

    assign scene_state = state;

    // Everything moves only on the tick so the renderer never sees a mid-frame change
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= COUNTDOWN;
            fcnt       <= '0;
            digit_idx  <= '0;
            idle       <= '0;
            cap        <= '0;
            anim_phase <= '0;
            seg_mask   <= COUNTDOWN_ROM[0];
        end else if (frame_tick) begin
            anim_phase <= anim_phase + ANIM_W'(1);
            case (state)
                COUNTDOWN: begin
                    fcnt      <= fcnt_next;
                    digit_idx <= digit_next;
                    seg_mask  <= COUNTDOWN_ROM[digit_next];
                    if (ui_in != '0) begin
                        cap   <= ui_in;
                        state <= ARMED;
                    end
                end
                ARMED: begin
                    fcnt      <= fcnt_next;
                    digit_idx <= digit_next;
                    if (ui_in == cap) begin
                        state    <= LIVE;
                        seg_mask <= cap;
                        idle     <= '0;
                    end else begin
                        seg_mask <= COUNTDOWN_ROM[digit_next];
                        if (ui_in != '0) cap   <= ui_in;
                        else             state <= COUNTDOWN;
                    end
                end
                LIVE: begin
                    seg_mask <= ui_in;
                    if (ui_in != '0) begin
                        idle <= '0;
                    end else if (idle_inc == IDLE_W'(IDLE_FRAMES)) begin
                        state     <= COUNTDOWN;
                        digit_idx <= '0;
                        fcnt      <= '0;
                        seg_mask  <= COUNTDOWN_ROM[0];
                        idle      <= '0;
                    end else begin
                        idle <= idle_inc;
                    end
                end
                default: state <= COUNTDOWN;
            endcase
        end
    end

endmodule
